// File: rtl/full_add_4.sv
// Four-bit ripple-carry adder with a combinational result and a registered
// result/valid/status stage. Status flags (zero_q, ovf_q) exist only when
// FULL_ADD_4_STATUS_EN is defined; otherwise they are tied to 0.
module full_add_4 #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    input  logic             en,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic [WIDTH-1:0] sum_q,
    output logic             c_out_q,
    output logic             valid_q,
    output logic             zero_q,
    output logic             ovf_q
);

    logic [WIDTH:0] carry;

    assign carry[0] = c_in;

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        assign sum[i]     = a[i] ^ b[i] ^ carry[i];
        assign carry[i+1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
    end

    assign c_out = carry[WIDTH];

    // ---- stage p0 -> p1: capture result on en ----
    logic [WIDTH-1:0] sum_p1;
    logic             c_out_p1;
    logic             vld_p1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sum_p1   <= '0;
            c_out_p1 <= 1'b0;
            vld_p1   <= 1'b0;
        end else if (en) begin
            sum_p1   <= sum;
            c_out_p1 <= c_out;
            vld_p1   <= 1'b1;
        end
    end

    assign sum_q   = sum_p1;
    assign c_out_q = c_out_p1;
    assign valid_q = vld_p1;

`ifdef FULL_ADD_4_STATUS_EN
    logic zero_p0;
    logic ovf_p0;
    logic zero_p1;
    logic ovf_p1;

    // Overflow: like-signed operands produce a result of the opposite sign.
    assign zero_p0 = ~|{c_out, sum};
    assign ovf_p0  = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            zero_p1 <= 1'b0;
            ovf_p1  <= 1'b0;
        end else if (en) begin
            zero_p1 <= zero_p0;
            ovf_p1  <= ovf_p0;
        end
    end

    assign zero_q = zero_p1;
    assign ovf_q  = ovf_p1;
`else
    assign zero_q = 1'b0;
    assign ovf_q  = 1'b0;
`endif

endmodule

// File: tb/tb_full_add_4.sv
// Self-checking bench for full_add_4: directed steps plus exhaustive and
// random sweeps against an arithmetic reference model.
module tb_full_add_4;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] a;
    logic [3:0] b;
    logic       c_in;
    logic       en;
    logic [3:0] sum;
    logic       c_out;
    logic [3:0] sum_q;
    logic       c_out_q;
    logic       valid_q;
    logic       zero_q;
    logic       ovf_q;

    int tests  = 0;
    int failed = 0;

    // Reference state of the registered stage
    logic [3:0] m_sum;
    logic       m_cout;
    logic       m_valid;
    logic       m_zero;
    logic       m_ovf;

    full_add_4 #(.WIDTH(4)) dut (
        .clk     (clk),
        .reset   (reset),
        .a       (a),
        .b       (b),
        .c_in    (c_in),
        .en      (en),
        .sum     (sum),
        .c_out   (c_out),
        .sum_q   (sum_q),
        .c_out_q (c_out_q),
        .valid_q (valid_q),
        .zero_q  (zero_q),
        .ovf_q   (ovf_q)
    );

    always #5 clk = ~clk;

    function automatic int ref_total(input int x, input int y, input int c);
        return x + y + c;
    endfunction

    // Signed overflow: the two's-complement total leaves the 4-bit range.
    function automatic logic ref_ovf(input int x, input int y, input int c);
        int sx;
        int sy;
        int s;
        sx = (x > 7) ? x - 16 : x;
        sy = (y > 7) ? y - 16 : y;
        s  = sx + sy + c;
        return (s > 7) || (s < -8);
    endfunction

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_comb(input string tag, input int exp_total);
        check({tag, ".sum"}, {4'b0, sum}, 8'(exp_total % 16));
        check({tag, ".c_out"}, {7'b0, c_out}, 8'(exp_total / 16));
    endtask

    task automatic check_q(input string tag);
        check({tag, ".sum_q"}, {4'b0, sum_q}, {4'b0, m_sum});
        check({tag, ".c_out_q"}, {7'b0, c_out_q}, {7'b0, m_cout});
        check({tag, ".valid_q"}, {7'b0, valid_q}, {7'b0, m_valid});
`ifdef FULL_ADD_4_STATUS_EN
        check({tag, ".zero_q"}, {7'b0, zero_q}, {7'b0, m_zero});
        check({tag, ".ovf_q"}, {7'b0, ovf_q}, {7'b0, m_ovf});
`else
        check({tag, ".zero_q"}, {7'b0, zero_q}, 8'h00);
        check({tag, ".ovf_q"}, {7'b0, ovf_q}, 8'h00);
`endif
    endtask

    task automatic model_clear();
        m_sum   = 4'h0;
        m_cout  = 1'b0;
        m_valid = 1'b0;
        m_zero  = 1'b0;
        m_ovf   = 1'b0;
    endtask

    // Drive inputs mid-cycle, check the combinational result, clock once,
    // then check the registered stage against the model.
    task automatic drive_step(input string tag, input int xa, input int xb,
                              input int xc, input logic xe);
        int total;
        a     = 4'(xa);
        b     = 4'(xb);
        c_in  = 1'(xc);
        en    = xe;
        total = ref_total(xa, xb, xc);
        #1;
        check_comb(tag, total);
        @(posedge clk);
        if (xe) begin
            m_sum   = 4'(total % 16);
            m_cout  = (total >= 16);
            m_valid = 1'b1;
            m_zero  = (total == 0);
            m_ovf   = ref_ovf(xa, xb, xc);
        end
        #1;
        check_q(tag);
    endtask

    task automatic comb_only(input string tag, input int xa, input int xb,
                             input int xc, input int exp_total);
        a    = 4'(xa);
        b    = 4'(xb);
        c_in = 1'(xc);
        #1;
        check_comb(tag, exp_total);
    endtask

    initial begin
        reset = 1'b0;
        en    = 1'b0;
        a     = 4'h0;
        b     = 4'h0;
        c_in  = 1'b0;
        model_clear();
        #1;
        reset = 1'b1;
        #1;
        check_q("reset_state");

        // Combinational path, with reset held high
        comb_only("zero",     0,  0, 0, 0);
        comb_only("3p4",      3,  4, 0, 7);
        comb_only("2p5",      2,  5, 0, 7);
        comb_only("9p9",      9,  9, 0, 18);
        comb_only("10p15",   10, 15, 0, 25);
        comb_only("10p5c",   10,  5, 1, 16);
        comb_only("15p15c",  15, 15, 1, 31);

        // en is ignored while reset is high
        en = 1'b1;
        @(posedge clk);
        #1;
        check_q("en_in_reset");
        reset = 1'b0;

        drive_step("capture",  10, 5, 1, 1'b1);
        drive_step("ovf_7p1",   7, 1, 0, 1'b1);
        drive_step("hold1",     3, 3, 0, 1'b0);
        drive_step("hold2",    12, 9, 1, 1'b0);
        drive_step("hold3",     0, 0, 0, 1'b0);
        drive_step("zero_cap",  0, 0, 0, 1'b1);
        drive_step("neg_ovf",   8, 8, 0, 1'b1);
        drive_step("hold4",     5, 6, 1, 1'b0);

        // Asynchronous reset between edges
        a    = 4'd9;
        b    = 4'd9;
        c_in = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        model_clear();
        check_q("async_reset");
        check_comb("comb_in_reset", 18);
        a = 4'd2;
        #1;
        check_comb("comb_track_reset", 11);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Exhaustive sweep, captured every cycle
        for (int i = 0; i < 512; i++) begin
            drive_step("exh", i % 16, (i / 16) % 16, i / 256, 1'b1);
        end

        // Random sweep with random enable
        for (int i = 0; i < 300; i++) begin
            drive_step("rnd", int'($urandom_range(15)), int'($urandom_range(15)),
                       int'($urandom_range(1)), 1'($urandom_range(1)));
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
